// File: rtl/c_pkg.sv
// Shared types for the multi-beat unary-code sequencer: inter-cell carry,
// FSM states and the per-bit unary cell evaluated by each beat slice.
package c_pkg;

  typedef struct packed {
    logic all_ones;
    logic all_zeros_n;
    logic seen_edge;
    logic is_unary;
    logic is_unary_n;
    logic x_prev;
  } c_carry_t;

  localparam c_carry_t C_CARRY_INIT = '{
    all_ones:    1'b0,
    all_zeros_n: 1'b0,
    seen_edge:   1'b0,
    is_unary:    1'b1,
    is_unary_n:  1'b1,
    x_prev:      1'b0
  };

  typedef enum logic [1:0] {
    C_IDLE,
    C_RUN,
    C_DONE
  } c_seq_state_t;

  // One bit position of the unary chain. A 1->0 step is legal only for a
  // unary code, 0->1 only for its complement; any second step kills both.
  function automatic c_carry_t c_unary_cell(input c_carry_t c, input logic x,
                                            input logic is_first, input logic admit_n);
    c_carry_t n;
    n        = c;
    n.x_prev = x;
    if (is_first) begin
      n.all_ones    = x;
      n.all_zeros_n = x;
      n.seen_edge   = 1'b0;
    end else begin
      n.all_ones    = c.all_ones & x;
      n.all_zeros_n = c.all_zeros_n | x;
      if (x != c.x_prev) begin
        n.seen_edge = 1'b1;
        if (c.seen_edge) begin
          n.is_unary   = 1'b0;
          n.is_unary_n = 1'b0;
        end else if (x) begin
          n.is_unary   = 1'b0;
        end else begin
          n.is_unary_n = 1'b0;
        end
      end
    end
    n.is_unary_n = n.is_unary_n & admit_n;
    return n;
  endfunction

endpackage

// File: rtl/c_seq_beat.sv
// Combinational slice: ripples the unary carry through P_BEAT_W bit cells
// and counts the ones in the beat.
module c_seq_beat
  import c_pkg::*;
#(
  parameter int P_BEAT_W              = 8,
  parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
  input  c_carry_t                        i_carry,
  input  logic [P_BEAT_W-1:0]             i_bits,
  input  logic                            i_is_first,
  output c_carry_t                        o_carry,
  output logic [$clog2(P_BEAT_W+1)-1:0]   o_pop
);

  localparam int   POP_W = $clog2(P_BEAT_W + 1);
  localparam logic ADMIT = (P_ADMIT_COMPLIMENT_EN != 0);

  c_carry_t chain;

  always_comb begin
    chain = i_carry;
    o_pop = '0;
    for (int unsigned i = 0; i < P_BEAT_W; i++) begin
      chain = c_unary_cell(chain, i_bits[i], i_is_first && (i == 0), ADMIT);
      o_pop = o_pop + POP_W'(i_bits[i]);
    end
    o_carry = chain;
  end

endmodule

// File: rtl/c_seq.sv
// Multi-beat unary / complemented-unary classifier: walks a P_W-bit word
// LSB-first, P_BEAT_W bits per cycle, and reports verdicts plus popcount.
module c_seq
  import c_pkg::*;
#(
  parameter int P_W                   = 64,
  parameter int P_BEAT_W              = 8,
  parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_in_vld,
  output logic                        o_in_rdy,
  input  logic [P_W-1:0]              i_in_dat,
  output logic                        o_out_vld,
  input  logic                        i_out_rdy,
  output logic                        o_is_unary,
  output logic                        o_is_unary_n,
  output logic [$clog2(P_W+1)-1:0]    o_len
);

  localparam int unsigned N_BEATS = P_W / P_BEAT_W;
  localparam int          LEN_W   = $clog2(P_W + 1);
  localparam int          POP_W   = $clog2(P_BEAT_W + 1);
  localparam int          BCNT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic        ADMIT   = (P_ADMIT_COMPLIMENT_EN != 0);

  c_seq_state_t         state, state_nxt;
  logic [P_W-1:0]       shreg;
  logic [BCNT_W-1:0]    beat_cnt;
  c_carry_t             carry, carry_nxt, carry_init;
  logic [LEN_W-1:0]     acc, acc_nxt;
  logic [POP_W-1:0]     beat_pop;
  logic                 res_u, res_un;
  logic [LEN_W-1:0]     res_len;
  logic                 accept, last_beat, dead, run_end;

  c_seq_beat #(
    .P_BEAT_W              (P_BEAT_W),
    .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
  ) u_beat (
    .i_carry    (carry),
    .i_bits     (shreg[P_BEAT_W-1:0]),
    .i_is_first (beat_cnt == '0),
    .o_carry    (carry_nxt),
    .o_pop      (beat_pop)
  );

  always_comb begin
    carry_init            = C_CARRY_INIT;
    carry_init.is_unary_n = ADMIT;
    acc_nxt   = acc + LEN_W'(beat_pop);
    last_beat = (beat_cnt == BCNT_W'(N_BEATS - 1));
    dead      = !carry_nxt.is_unary && !carry_nxt.is_unary_n;
    run_end   = last_beat || dead;
    accept    = i_in_vld && o_in_rdy;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= C_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:  if (accept)    state_nxt = C_RUN;
      C_RUN:   if (run_end)   state_nxt = C_DONE;
      C_DONE:  if (i_out_rdy) state_nxt = accept ? C_RUN : C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Ready reaches back through i_out_rdy so a new word can land in DONE.
  always_comb begin
    o_in_rdy     = (state == C_IDLE) || ((state == C_DONE) && i_out_rdy);
    o_out_vld    = (state == C_DONE);
    o_is_unary   = res_u;
    o_is_unary_n = res_un;
    o_len        = res_len;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      shreg    <= '0;
      beat_cnt <= '0;
      carry    <= '0;
      acc      <= '0;
      res_u    <= 1'b0;
      res_un   <= 1'b0;
      res_len  <= '0;
    end else if (accept) begin
      shreg    <= i_in_dat;
      beat_cnt <= '0;
      carry    <= carry_init;
      acc      <= '0;
    end else if (state == C_RUN) begin
      shreg    <= shreg >> P_BEAT_W;
      beat_cnt <= beat_cnt + 1'b1;
      carry    <= carry_nxt;
      acc      <= acc_nxt;
      if (run_end) begin
        res_u   <= carry_nxt.is_unary;
        res_un  <= carry_nxt.is_unary_n;
        res_len <= (carry_nxt.is_unary || carry_nxt.is_unary_n) ? acc_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_c_seq.sv
// Directed bench for c_seq (P_W=16, P_BEAT_W=4): one instance admits the
// complement, a second has it disabled; both see the same stimulus.
module tb_c_seq;

  localparam int P_W = 16;
  localparam int P_BEAT_W = 4;
  localparam int LEN_W = $clog2(P_W + 1);

  typedef struct {
    logic [15:0] dat;
    int u1, un1, len1, lat1;
    int u0, un0, len0, lat0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0;
  logic out_rdy = 1'b0;
  logic [P_W-1:0] in_dat = '0;

  logic in_rdy1, out_vld1, u1, un1;
  logic [LEN_W-1:0] len1;
  logic in_rdy0, out_vld0, u0, un0;
  logic [LEN_W-1:0] len0;

  int n_tests = 0;
  int n_fail = 0;
  vec_t vecs [13];

  always #5 clk = ~clk;

  c_seq #(.P_W(P_W), .P_BEAT_W(P_BEAT_W), .P_ADMIT_COMPLIMENT_EN(1)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_in_vld(in_vld), .o_in_rdy(in_rdy1),
    .i_in_dat(in_dat), .o_out_vld(out_vld1), .i_out_rdy(out_rdy),
    .o_is_unary(u1), .o_is_unary_n(un1), .o_len(len1)
  );

  c_seq #(.P_W(P_W), .P_BEAT_W(P_BEAT_W), .P_ADMIT_COMPLIMENT_EN(0)) dut0 (
    .i_clk(clk), .i_arst_n(rst_n), .i_in_vld(in_vld), .o_in_rdy(in_rdy0),
    .i_in_dat(in_dat), .o_out_vld(out_vld0), .i_out_rdy(out_rdy),
    .o_is_unary(u0), .o_is_unary_n(un0), .o_len(len0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Counts edges after the accept edge until each instance shows o_out_vld.
  task automatic wait_results(output int l1, output int l0);
    l1 = -1;
    l0 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (out_vld1 && l1 < 0) l1 = k;
      if (out_vld0 && l0 < 0) l0 = k;
      if (l1 >= 0 && l0 >= 0) break;
    end
  endtask

  task automatic send(input logic [15:0] dat);
    @(negedge clk);
    in_vld = 1'b1;
    in_dat = dat;
    #1;
    check($sformatf("in_rdy_%h", dat), int'(in_rdy1 & in_rdy0), 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_dat = 16'hA5C3;
  endtask

  task automatic drain();
    @(negedge clk);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("drained_vld", int'(out_vld1 | out_vld0), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int l1, l0;
    send(v.dat);
    wait_results(l1, l0);
    check($sformatf("lat1_%h", v.dat), l1, v.lat1);
    check($sformatf("u1_%h", v.dat), int'(u1), v.u1);
    check($sformatf("un1_%h", v.dat), int'(un1), v.un1);
    check($sformatf("len1_%h", v.dat), int'(len1), v.len1);
    check($sformatf("lat0_%h", v.dat), l0, v.lat0);
    check($sformatf("u0_%h", v.dat), int'(u0), v.u0);
    check($sformatf("un0_%h", v.dat), int'(un0), v.un0);
    check($sformatf("len0_%h", v.dat), int'(len0), v.len0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l0;
    //            dat       u1 un1 len1 lat1  u0 un0 len0 lat0
    vecs[0]  = '{16'h00FF,  1, 0,  8,  4,    1, 0,  8,  4};
    vecs[1]  = '{16'hFF00,  0, 1,  8,  4,    0, 0,  0,  3};
    vecs[2]  = '{16'h0000,  1, 1,  0,  4,    1, 0,  0,  4};
    vecs[3]  = '{16'hFFFF,  1, 1, 16,  4,    1, 0, 16,  4};
    vecs[4]  = '{16'h0007,  1, 0,  3,  4,    1, 0,  3,  4};
    vecs[5]  = '{16'h0F80,  0, 0,  0,  4,    0, 0,  0,  2};
    vecs[6]  = '{16'h000A,  0, 0,  0,  1,    0, 0,  0,  1};
    vecs[7]  = '{16'h8000,  0, 1,  1,  4,    0, 0,  0,  4};
    vecs[8]  = '{16'h0001,  1, 0,  1,  4,    1, 0,  1,  4};
    vecs[9]  = '{16'hFFFE,  0, 1, 15,  4,    0, 0,  0,  1};
    vecs[10] = '{16'h00F0,  0, 0,  0,  3,    0, 0,  0,  2};
    vecs[11] = '{16'h000F,  1, 0,  4,  4,    1, 0,  4,  4};
    vecs[12] = '{16'h0300,  0, 0,  0,  3,    0, 0,  0,  3};

    // Reset state
    #12;
    check("rst_vld", int'(out_vld1), 0);
    check("rst_u", int'(u1), 0);
    check("rst_un", int'(un1), 0);
    check("rst_len", int'(len1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdy", int'(in_rdy1), 1);
    check("post_rst_vld", int'(out_vld1), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure hold, then back-to-back accept out of DONE
    send(16'h00FF);
    wait_results(l1, l0);
    check("hold_lat", l1, 4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_vld_%0d", k), int'(out_vld1), 1);
      check($sformatf("hold_rdy_%0d", k), int'(in_rdy1), 0);
      check($sformatf("hold_u_%0d", k), int'(u1), 1);
      check($sformatf("hold_un_%0d", k), int'(un1), 0);
      check($sformatf("hold_len_%0d", k), int'(len1), 8);
    end
    @(negedge clk);
    out_rdy = 1'b1;
    in_vld = 1'b1;
    in_dat = 16'h0007;
    #1;
    check("b2b_rdy", int'(in_rdy1), 1);
    @(posedge clk); #1;
    out_rdy = 1'b0;
    in_vld = 1'b0;
    in_dat = 16'h5A5A;
    check("b2b_run_vld", int'(out_vld1), 0);
    check("b2b_run_rdy", int'(in_rdy1), 0);
    wait_results(l1, l0);
    check("b2b_lat", l1, 4);
    check("b2b_u", int'(u1), 1);
    check("b2b_un", int'(un1), 0);
    check("b2b_len", int'(len1), 3);
    drain();

    // Asynchronous reset during beat 2
    send(16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_vld", int'(out_vld1), 0);
    check("arst_rdy_idle", int'(in_rdy1), 1);
    check("arst_len", int'(len1), 0);
    @(posedge clk); #1;
    check("arst_hold_vld", int'(out_vld1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_release_rdy", int'(in_rdy1), 1);
    run_vec('{16'h0003, 1, 0, 2, 4, 1, 0, 2, 4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
